matmul_calc_core: RTL and testbench
===================================

# matmul_calc_core

Output-stationary systolic matrix multiplier computing R = A·B + C for square MAX_DIM×MAX_DIM unsigned matrices, with MAX_DIM = BUS_WIDTH/DATA_WIDTH. The caller streams skewed rows of A and skewed columns of B one vector per clock. The block accumulates every product in a grid of processing elements (PEs), one per result element. It is the compute core behind the matmul register/bus front-end.

## Interface
- DATA_WIDTH, default 8: operand element width in bits.
- BUS_WIDTH, default 32: accumulator/result element width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (must divide exactly, MAX_DIM ≥ 2).
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- start_operation_i  input  1  enable; high = run/accumulate, low = synchronous clear.
- a_flat_i  input  DATA_WIDTH*MAX_DIM  lane i (bits [i*DATA_WIDTH +: DATA_WIDTH]) enters PE row i from the left.
- b_flat_i  input  DATA_WIDTH*MAX_DIM  lane j enters PE column j from the top.
- c_flat_i  input  BUS_WIDTH*MAX_DIM*MAX_DIM  bias matrix; element (i,j) at [(i*MAX_DIM+j)*BUS_WIDTH +: BUS_WIDTH].
- result_flat_o  output  BUS_WIDTH*MAX_DIM*MAX_DIM  result matrix, same packing as c_flat_i.
- ov_reg_o  output  MAX_DIM*MAX_DIM  sticky overflow flag per element, bit i*MAX_DIM+j.

## Operation
- Each PE(i,j) holds a_reg and b_reg (DATA_WIDTH) and acc (BUS_WIDTH).
  - a_reg feeds PE(i,j+1); b_reg feeds PE(i+1,j).
  - Row-0 PEs take b from b_flat_i; column-0 PEs take a from a_flat_i.
- start_operation_i high, each edge:
  - a_reg ← a_in, b_reg ← b_in.
  - acc ← acc + a_in*b_in, unsigned; the 2*DATA_WIDTH product is zero-extended to BUS_WIDTH.
- start_operation_i low, each edge: a_reg, b_reg, acc and ov cleared to 0.
- result element (i,j) = acc(i,j) + c(i,j), combinational, truncated to BUS_WIDTH. C is sampled live, so it must be stable while the result is read.
- Overflow, ov(i,j):
  - Set on any edge where the acc addition carries out of BUS_WIDTH.
  - Also asserted combinationally whenever acc + c carries out.
  - The acc-carry part is sticky until clear or reset.
- Caller input format:
  - Lane i carries A[i][t−i] at input cycle t, for 0 ≤ t−i < MAX_DIM, else 0.
  - Lane j carries B[t−j][j] under the same rule.
  - Zeros are fed after the last element.

## Timing
- Reset (async): all PE registers and ov = 0. result_flat_o then equals c_flat_i and ov_reg_o = 0.
- Product A[i][k]*B[k][j] reaches PE(i,j) at input cycle k+i+j (cycle 0 = first edge with start high).
- Element (i,j) is final after the edge at cycle i+j+MAX_DIM−1. The full matrix is valid after 3*MAX_DIM−2 edges with start high, and stays valid while start stays high and zeros are fed.
- Nonzero inputs after completion corrupt the result; the caller must hold the inputs at zero.
- Reset mid-operation: immediate clear; the operation must be restarted from cycle 0.
- start dropped mid-operation: clear on the next edge; there is no pause/resume.
- No handshake or done signal; completion is by cycle count.

## Configuration
- MATMUL_CALC_OV_EN defined: overflow detection logic present, ov_reg_o behaves as above.
- MATMUL_CALC_OV_EN undefined: no carry logic; ov_reg_o tied to 0. Arithmetic wraps identically in both builds.

## Test plan
All scenarios use DATA_WIDTH=8, BUS_WIDTH=32.
- Product: A = B = [[1,2,3,4],[5,6,7,8],[8,7,6,5],[4,3,2,1]], C=0, streamed skewed over 7 cycles then zeros, result read after ≥10 edges. Required result rows [51,47,43,39], [123,119,115,111], [111,115,119,123], [39,43,47,51]; ov_reg_o=0.
- Bias: same A, B with every c element = 1 → every result element +1.
- Identity: A=I, B as above → result equals B. Also check element (0,0) is final after cycle 3 and (3,3) after cycle 9.
- Overflow: A=B=all 255, c(0,0)=0xFFFFFFFF, other c = 0.
  - Required: result(1,1)=260100.
  - Required: ov bit 0 = 1 and all other ov bits = 0 when MATMUL_CALC_OV_EN is defined; ov_reg_o = 0 when it is undefined.
- Clear/reset:
  - Drop start after the product test → next edge result = C, ov = 0.
  - Assert rst_n_i low mid-stream (cycle 3) → outputs clear without waiting for a clock edge.
  - Restarting the product test then yields the values above.

Source files
------------

// File: rtl/matmul_calc_core.sv
// Output-stationary systolic R = A*B + C core: a MAX_DIM x MAX_DIM grid of accumulating PEs.
// Optional MATMUL_CALC_OV_EN adds per-element sticky carry-out detection on ov_reg_o.
module matmul_calc_pe #(
  parameter int DW = 8,
  parameter int BW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [BW-1:0] c_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [BW-1:0] res_o,
  output logic          ov_o
);
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [2*DW-1:0] prod;

  assign prod = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
  assign a_o  = a_q;
  assign b_o  = b_q;

`ifdef MATMUL_CALC_OV_EN
  logic        ov_q, ov_d;
  logic [BW:0] acc_sum, res_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, BW'(prod)};
  assign res_sum = {1'b0, acc_q} + {1'b0, c_i};
  assign res_o   = res_sum[BW-1:0];
  // Bias carry is live with C; only the accumulator carry is remembered.
  assign ov_o    = ov_q | res_sum[BW];

  always_comb begin
    ov_d = 1'b0;
    if (en_i) ov_d = ov_q | acc_sum[BW];
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) ov_q <= 1'b0;
    else          ov_q <= ov_d;
`else
  logic [BW-1:0] acc_sum;

  assign acc_sum = acc_q + BW'(prod);
  assign res_o   = acc_q + c_i;
  assign ov_o    = 1'b0;
`endif

  always_comb begin
    a_d   = '0;
    b_d   = '0;
    acc_d = '0;
    if (en_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = acc_sum[BW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
endmodule

module matmul_calc_core #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   start_operation_i,
  input  logic [DATA_WIDTH*MAX_DIM-1:0]          a_flat_i,
  input  logic [DATA_WIDTH*MAX_DIM-1:0]          b_flat_i,
  input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]   c_flat_i,
  output logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]   result_flat_o,
  output logic [MAX_DIM*MAX_DIM-1:0]             ov_reg_o
);
  // a_h[i][j] enters PE(i,j) from the left; b_v[i][j] enters PE(i,j) from the top.
  logic [MAX_DIM-1:0][MAX_DIM:0][DATA_WIDTH-1:0] a_h;
  logic [MAX_DIM:0][MAX_DIM-1:0][DATA_WIDTH-1:0] b_v;
  logic unused_edge;

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
    assign a_h[i][0] = a_flat_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_v[0][i] = b_flat_i[i*DATA_WIDTH +: DATA_WIDTH];
    for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
      matmul_calc_pe #(.DW(DATA_WIDTH), .BW(BUS_WIDTH)) u_pe (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .en_i   (start_operation_i),
        .a_i    (a_h[i][j]),
        .b_i    (b_v[i][j]),
        .c_i    (c_flat_i[(i*MAX_DIM+j)*BUS_WIDTH +: BUS_WIDTH]),
        .a_o    (a_h[i][j+1]),
        .b_o    (b_v[i+1][j]),
        .res_o  (result_flat_o[(i*MAX_DIM+j)*BUS_WIDTH +: BUS_WIDTH]),
        .ov_o   (ov_reg_o[i*MAX_DIM+j])
      );
    end
  end

  // Operands falling off the right/bottom edges have no consumer.
  always_comb begin
    unused_edge = 1'b0;
    for (int k = 0; k < MAX_DIM; k++)
      unused_edge = unused_edge ^ (^a_h[k][MAX_DIM]) ^ (^b_v[MAX_DIM][k]);
  end
endmodule

// File: tb/tb_matmul_calc_core.sv
// Directed table-driven bench for matmul_calc_core (4x4, 8-bit operands, 32-bit results).
module tb_matmul_calc_core;
  typedef logic [7:0]  mat_t [0:3][0:3];
  typedef logic [31:0] res_t [0:3][0:3];
  typedef struct {
    mat_t        a;
    mat_t        b;
    logic [31:0] c00;
    logic [31:0] crest;
    res_t        r;
    logic [15:0] ov;
  } vec_t;

`ifdef MATMUL_CALC_OV_EN
  localparam bit OV_ON = 1'b1;
`else
  localparam bit OV_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [3:0][7:0]    a_flat, b_flat;
  logic [15:0][31:0]  c_flat, res_flat;
  logic [15:0]        ov;
  int                 errors = 0;
  int                 checks = 0;

  always #5 clk = ~clk;

  matmul_calc_core #(.DATA_WIDTH(8), .BUS_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .start_operation_i(start),
    .a_flat_i         (a_flat),
    .b_flat_i         (b_flat),
    .c_flat_i         (c_flat),
    .result_flat_o    (res_flat),
    .ov_reg_o         (ov)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic set_c(input logic [31:0] c00, input logic [31:0] crest);
    for (int k = 0; k < 16; k++) c_flat[k] = (k == 0) ? c00 : crest;
  endtask

  // Drive skewed lanes for input cycle t, then let the edge happen.
  task automatic step(input mat_t a, input mat_t b, input int t);
    @(negedge clk);
    start = 1'b1;
    for (int l = 0; l < 4; l++) begin
      a_flat[l] = (t - l >= 0 && t - l < 4) ? a[l][t-l] : 8'd0;
      b_flat[l] = (t - l >= 0 && t - l < 4) ? b[t-l][l] : 8'd0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_mm(input mat_t a, input mat_t b);
    for (int t = 0; t < 10; t++) step(a, b, t);
    @(negedge clk);
    a_flat = '0;
    b_flat = '0;
  endtask

  task automatic clear_and_check(input string name);
    @(negedge clk);
    start  = 1'b0;
    a_flat = '0;
    b_flat = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) chk($sformatf("%s r[%0d]", name, k), res_flat[k], c_flat[k]);
    chk({name, " ov"}, {16'd0, ov}, 32'd0);
  endtask

  vec_t vecs[4];
  mat_t m_ab, m_id, m_ff;
  res_t r_prod;

  initial begin
    m_ab   = '{'{1,2,3,4}, '{5,6,7,8}, '{8,7,6,5}, '{4,3,2,1}};
    r_prod = '{'{51,47,43,39}, '{123,119,115,111}, '{111,115,119,123}, '{39,43,47,51}};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        m_id[i][j] = (i == j) ? 8'd1 : 8'd0;
        m_ff[i][j] = 8'd255;
      end

    vecs[0] = '{a: m_ab, b: m_ab, c00: 0, crest: 0, r: r_prod, ov: 16'h0};
    vecs[1] = '{a: m_ab, b: m_ab, c00: 1, crest: 1, r: r_prod, ov: 16'h0};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) vecs[1].r[i][j] = r_prod[i][j] + 1;
    vecs[2] = '{a: m_id, b: m_ab, c00: 0, crest: 0, r: r_prod, ov: 16'h0};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) vecs[2].r[i][j] = {24'd0, m_ab[i][j]};
    vecs[3] = '{a: m_ff, b: m_ff, c00: 32'hFFFF_FFFF, crest: 0, r: r_prod, ov: OV_ON ? 16'h1 : 16'h0};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) vecs[3].r[i][j] = 32'd260100;
    vecs[3].r[0][0] = 32'd260099;

    rst_n  = 1'b0;
    start  = 1'b0;
    a_flat = '0;
    b_flat = '0;
    set_c(32'd7, 32'd3);
    #12;
    for (int k = 0; k < 16; k++) chk($sformatf("reset r[%0d]", k), res_flat[k], c_flat[k]);
    chk("reset ov", {16'd0, ov}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      set_c(vecs[v].c00, vecs[v].crest);
      run_mm(vecs[v].a, vecs[v].b);
      #1;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          chk($sformatf("vec%0d r(%0d,%0d)", v, i, j), res_flat[i*4+j], vecs[v].r[i][j]);
      chk($sformatf("vec%0d ov", v), {16'd0, ov}, {16'd0, vecs[v].ov});
      if (v == 0) begin
        // Result must hold while start stays high and zeros are fed.
        repeat (3) @(posedge clk);
        #1;
        chk("hold r(2,1)", res_flat[9], 32'd115);
        chk("hold r(3,3)", res_flat[15], 32'd51);
      end
      clear_and_check($sformatf("clear%0d", v));
    end

    // Identity skew timing: (0,0) done early, (3,3) lands exactly on cycle 9.
    set_c(0, 0);
    for (int t = 0; t < 10; t++) begin
      step(m_id, m_ab, t);
      if (t == 3) chk("id r(0,0)@3", res_flat[0], 32'd1);
      if (t == 8) chk("id r(3,3)@8", res_flat[15], 32'd0);
      if (t == 9) chk("id r(3,3)@9", res_flat[15], 32'd1);
    end
    clear_and_check("id clear");

    // Async reset mid-stream, then restart from cycle 0.
    for (int t = 0; t < 4; t++) begin
      step(m_ab, m_ab, t);
      if (t == 2) chk("prod r(0,0)@2", res_flat[0], 32'd35);
      if (t == 3) chk("prod r(0,0)@3", res_flat[0], 32'd51);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst r(0,0)", res_flat[0], 32'd0);
    chk("async rst r(1,0)", res_flat[4], 32'd0);
    chk("async rst ov", {16'd0, ov}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    run_mm(m_ab, m_ab);
    #1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("restart r(%0d,%0d)", i, j), res_flat[i*4+j], r_prod[i][j]);
    chk("restart ov", {16'd0, ov}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
